// File: rtl/fp_div_pkg.sv
// Shared types and constants for the float divider operand path.
package fp_div_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 8;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Operand-stage sequencing: capture, normalise, round/pack, present.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/u32_to_fp_norm.sv
// One unsigned 32-bit to IEEE-754 single converter lane: holds the working
// register and shift count, normalises one bit per enabled cycle, and offers
// the round-to-nearest-even packed result combinationally.
module u32_to_fp_norm
  import fp_div_pkg::*;
#(
  parameter int BIAS = FP_BIAS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        shift_en,
  input  logic [31:0] value,
  output logic        done,
  output logic [31:0] fp
);

  // Exponent for a value whose leading one already sits in bit 31.
  localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(BIAS + 31);

  logic [31:0]          work_q;
  logic [4:0]           cnt_q;
  logic                 zero_q;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [FP_MANT_W:0]   mant_sum;
  logic [FP_EXP_W-1:0]  exp_val;

  // A lane is finished once normalised or when it holds zero (never normalises).
  assign done = zero_q | work_q[31];

  // Capture a new operand, or shift it one place toward bit 31.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
    end else if (load) begin
      work_q <= value;
      cnt_q  <= '0;
      zero_q <= (value == '0);
    end else if (shift_en && !done) begin
      work_q <= {work_q[30:0], 1'b0};
      cnt_q  <= cnt_q + 5'd1;
    end
  end

  // Round to nearest even on the bits below the 23-bit mantissa and pack.
  // NOTE: every output of this block is given a default first so no latch
  // can be inferred on any path.
  always_comb begin
    guard    = work_q[7];
    sticky   = |work_q[6:0];
    round_up = guard & (sticky | work_q[8]);
    mant_sum = {1'b0, work_q[30:8]} + {{FP_MANT_W{1'b0}}, round_up};
    // A mantissa carry-out leaves the low 23 bits zero and bumps the exponent.
    exp_val  = EXP_TOP - {3'b000, cnt_q} + {{(FP_EXP_W-1){1'b0}}, mant_sum[FP_MANT_W]};
    fp       = zero_q ? FP_ZERO : {1'b0, exp_val, mant_sum[FP_MANT_W-1:0]};
  end

endmodule

// File: rtl/int_to_fp_operand_stage.sv
// Operand stage for the float divider: accepts an unsigned numerator and
// denominator pair, converts both to IEEE-754 single, and hands the pair plus
// a divide-by-zero flag downstream. One pair in flight at a time.
module int_to_fp_operand_stage
  import fp_div_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BIAS = FP_BIAS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] num_int,
  input  logic [XLEN-1:0] den_int,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] num_fp,
  output logic [XLEN-1:0] den_fp,
  output logic            div_by_zero
);

  state_e      state_q;
  state_e      state_d;
  logic        load;
  logic        shift_en;
  logic        num_done;
  logic        den_done;
  logic [31:0] num_fp_c;
  logic [31:0] den_fp_c;

  assign in_ready = (state_q == IDLE);
  assign load     = in_ready & in_valid;
  assign shift_en = (state_q == NORM);

  u32_to_fp_norm #(.BIAS(BIAS)) u_num (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .value    (num_int),
    .done     (num_done),
    .fp       (num_fp_c)
  );

  u32_to_fp_norm #(.BIAS(BIAS)) u_den (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .value    (den_int),
    .done     (den_done),
    .fp       (den_fp_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: normalise until both lanes are done, then round, then hold.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)             state_d = NORM;
      NORM:    if (num_done && den_done) state_d = ROUND;
      ROUND:                             state_d = OUT;
      OUT:     if (out_ready)            state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Output registers: loaded in ROUND, held through OUT, kept after handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      num_fp      <= '0;
      den_fp      <= '0;
      div_by_zero <= 1'b0;
    end else if (state_q == ROUND) begin
      out_valid   <= 1'b1;
      num_fp      <= num_fp_c;
      den_fp      <= den_fp_c;
      // Only a zero operand packs to all-zero bits.
      div_by_zero <= (den_fp_c == FP_ZERO);
    end else if (state_q == OUT && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int_to_fp_operand_stage.sv
// Directed bench for int_to_fp_operand_stage with hand-computed float values.
module tb_int_to_fp_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num_int;
  logic [31:0] den_int;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] num_fp;
  logic [31:0] den_fp;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_to_fp_operand_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .num_int     (num_int),
    .den_int     (den_int),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .num_fp      (num_fp),
    .den_fp      (den_fp),
    .div_by_zero (div_by_zero)
  );

  // Drive a pair until accepted, then count cycles to out_valid.
  // Cycle 0 ends at the capture edge, so out_valid is expected in cycle 3+k.
  task automatic send_pair(input logic [31:0] n, input logic [31:0] d,
                           input bit keep_valid, output int lat, output bit ok);
    int t;
    ok = 1'b1;
    num_int  = n;
    den_int  = d;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) ok = 1'b0;
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) ok = 1'b0;
  endtask

  // Complete the output handshake in one cycle.
  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; num_int = '0; den_int = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || num_fp !== 32'h0 ||
        den_fp !== 32'h0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: ov=%b ir=%b num=%h den=%h dbz=%b, want 0 1 0 0 0",
               out_valid, in_ready, num_fp, den_fp, div_by_zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_min_values();
    int lat; bit ok;
    send_pair(32'd1, 32'd2, 1'b0, lat, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL one_two_timeout: handshake bound expired"); end
    n_checks++;
    if (num_fp !== 32'h3F800000 || den_fp !== 32'h40000000 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL one_two_value: got %h/%h dbz=%b, want 3f800000/40000000 dbz=0",
               num_fp, den_fp, div_by_zero);
    end
    n_checks++;
    if (lat !== 34) begin n_fail++; $display("FAIL one_two_latency: got %0d, want 34", lat); end
    take_output();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL one_two_release: ov=%b ir=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_round_carry();
    int lat; bit ok;
    send_pair(32'hFFFFFFFF, 32'h80000000, 1'b0, lat, ok);
    n_checks++;
    if (!ok || num_fp !== 32'h4F800000 || den_fp !== 32'h4F000000) begin
      n_fail++;
      $display("FAIL round_carry: got %h/%h ok=%b, want 4f800000/4f000000", num_fp, den_fp, ok);
    end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL round_carry_latency: got %0d, want 3", lat); end
    take_output();
  endtask

  task automatic test_ties_and_zero();
    int lat; bit ok;
    // Tie with even mantissa stays; divisor zero raises the flag.
    send_pair(32'h01000001, 32'h0, 1'b0, lat, ok);
    n_checks++;
    if (!ok || num_fp !== 32'h4B800000 || den_fp !== 32'h0 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_even_zero: got %h/%h dbz=%b, want 4b800000/00000000 dbz=1",
               num_fp, den_fp, div_by_zero);
    end
    n_checks++;
    if (lat !== 10) begin n_fail++; $display("FAIL tie_even_latency: got %0d, want 10", lat); end
    take_output();
    // Tie with odd mantissa rounds up; denominator 1 clears the flag.
    send_pair(32'h01000003, 32'd1, 1'b0, lat, ok);
    n_checks++;
    if (!ok || num_fp !== 32'h4B800002 || den_fp !== 32'h3F800000 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_odd: got %h/%h dbz=%b, want 4b800002/3f800000 dbz=0",
               num_fp, den_fp, div_by_zero);
    end
    take_output();
  endtask

  task automatic test_backpressure();
    int lat; bit ok;
    send_pair(32'd6, 32'd3, 1'b0, lat, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout: handshake bound expired"); end
    // Offer a competing pair while the result is stalled.
    num_int = 32'd7; den_int = 32'd7; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          num_fp !== 32'h40C00000 || den_fp !== 32'h40400000) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: ov=%b ir=%b %h/%h, want 1 0 40c00000/40400000",
                 i, out_valid, in_ready, num_fp, den_fp);
      end
    end
    in_valid = 1'b0;
    take_output();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || num_fp !== 32'h40C00000) begin
      n_fail++;
      $display("FAIL bp_release: ov=%b ir=%b num=%h, want 0 1 40c00000",
               out_valid, in_ready, num_fp);
    end
  endtask

  task automatic test_reset_mid_norm();
    int lat; bit ok;
    num_int = 32'd1; den_int = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || num_fp !== 32'h0 || den_fp !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: ov=%b ir=%b %h/%h, want 0 1 0/0",
               out_valid, in_ready, num_fp, den_fp);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send_pair(32'd3, 32'd5, 1'b0, lat, ok);
    n_checks++;
    if (!ok || num_fp !== 32'h40400000 || den_fp !== 32'h40A00000) begin
      n_fail++;
      $display("FAIL after_reset: got %h/%h ok=%b, want 40400000/40a00000", num_fp, den_fp, ok);
    end
    take_output();
  endtask

  task automatic test_back_to_back();
    int lat; bit ok;
    send_pair(32'd6, 32'd3, 1'b1, lat, ok);
    // Swap in the second pair while the first is still in flight.
    num_int = 32'd10; den_int = 32'd4;
    n_checks++;
    if (!ok || num_fp !== 32'h40C00000 || den_fp !== 32'h40400000) begin
      n_fail++;
      $display("FAIL b2b_first: got %h/%h ok=%b, want 40c00000/40400000", num_fp, den_fp, ok);
    end
    take_output();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: ir=%b ov=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: ir=%b, want 0 after second capture", in_ready);
    end
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (num_fp !== 32'h41200000 || den_fp !== 32'h40800000 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got %h/%h ov=%b, want 41200000/40800000 ov=1",
               num_fp, den_fp, out_valid);
    end
    n_checks++;
    if (lat !== 32) begin n_fail++; $display("FAIL b2b_latency: got %0d, want 32", lat); end
    take_output();
  endtask

  initial begin
    test_reset();
    test_min_values();
    test_round_carry();
    test_ties_and_zero();
    test_backpressure();
    test_reset_mid_norm();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
